// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Opcodes, flag bit positions and FSM states shared by alu_pipe.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int OP_ADD   = 0;
    localparam int OP_ADC   = 1;
    localparam int OP_SUB   = 2;
    localparam int OP_SBC   = 3;
    localparam int OP_AND   = 4;
    localparam int OP_OR    = 5;
    localparam int OP_XOR   = 6;
    localparam int OP_NOT   = 7;
    localparam int OP_SHL   = 8;
    localparam int OP_SHR   = 9;
    localparam int OP_ASR   = 10;
    localparam int OP_PASSA = 11;
    localparam int OP_PASSB = 12;
    localparam int OP_INC   = 13;
    localparam int OP_DEC   = 14;
    localparam int OP_MUL   = 15;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_iter
// Purpose  : Iterative shift-add multiplier, one partial product per cycle.
// Revision : 1.0
// ============================================================================
module alu_mul_iter #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int              c_cw       = $clog2(WIDTH);
    localparam logic [c_cw-1:0] c_cnt_init = c_cw'(WIDTH - 1);
    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_cw-1:0]    r_cnt;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    // The final step's sum is presented combinationally so the caller can
    // load it on the same edge that retires the last iteration.
    assign product    = w_acc_next;
    assign done       = r_busy && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= c_cnt_init;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Registered valid/ready ALU with persistent NZVC flags and an
//            iterative multiplier.
// Revision : 1.0
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int c_shw = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;

    logic               w_accept;
    logic               w_op_mul;
    logic               w_load;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_prod;

    logic [WIDTH-1:0]   w_add_y;
    logic               w_add_cin;
    logic [WIDTH:0]     w_sum;
    logic               w_add_v;
    logic [c_shw-1:0]   w_sh;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH:0]     w_asr;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [WIDTH-1:0]   w_ld_res;
    logic [3:0]         w_ld_flags;

    assign in_ready  = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;
    assign w_accept  = in_valid && in_ready;
    assign w_op_mul  = (op == OPW'(OP_MUL));

    // Whole add/sub family shares one adder: a + y + cin.
    always_comb begin
        w_add_y   = b;
        w_add_cin = 1'b0;
        case (op)
            OPW'(OP_ADC): w_add_cin = r_flags[FLAG_C];
            OPW'(OP_SUB): begin w_add_y = ~b; w_add_cin = 1'b1;             end
            OPW'(OP_SBC): begin w_add_y = ~b; w_add_cin = r_flags[FLAG_C];  end
            OPW'(OP_INC): begin w_add_y = '0; w_add_cin = 1'b1;             end
            OPW'(OP_DEC): begin w_add_y = '1; w_add_cin = 1'b0;             end
            default: ;
        endcase
    end

    assign w_sum   = {1'b0, a} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_add_v = (a[WIDTH-1] == w_add_y[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

    // One guard bit beyond the data catches the last bit shifted out.
    assign w_sh  = b[c_shw-1:0];
    assign w_shl = {1'b0, a} << w_sh;
    assign w_shr = {a, 1'b0} >> w_sh;
    assign w_asr = $signed({a, 1'b0}) >>> w_sh;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            OPW'(OP_ADD), OPW'(OP_ADC), OPW'(OP_SUB),
            OPW'(OP_SBC), OPW'(OP_INC), OPW'(OP_DEC): begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_add_v;
            end
            OPW'(OP_AND):   w_res = a & b;
            OPW'(OP_OR):    w_res = a | b;
            OPW'(OP_XOR):   w_res = a ^ b;
            OPW'(OP_NOT):   w_res = ~a;
            OPW'(OP_SHL):   begin w_res = w_shl[WIDTH-1:0]; w_c = w_shl[WIDTH]; end
            OPW'(OP_SHR):   begin w_res = w_shr[WIDTH:1];   w_c = w_shr[0];     end
            OPW'(OP_ASR):   begin w_res = w_asr[WIDTH:1];   w_c = w_asr[0];     end
            OPW'(OP_PASSA): w_res = a;
            OPW'(OP_PASSB): w_res = b;
            default: ;
        endcase
    end

    always_comb begin
        w_ld_res             = (r_state == ST_MUL) ? w_mul_prod[WIDTH-1:0] : w_res;
        w_ld_flags           = '0;
        w_ld_flags[FLAG_N]   = w_ld_res[WIDTH-1];
        w_ld_flags[FLAG_Z]   = (w_ld_res == '0);
        w_ld_flags[FLAG_V]   = (r_state == ST_MUL) ? 1'b0 : w_v;
        w_ld_flags[FLAG_C]   = (r_state == ST_MUL) ? |w_mul_prod[2*WIDTH-1:WIDTH] : w_c;
    end

    always_comb begin
        w_state_next = r_state;
        w_mul_start  = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_op_mul) begin
                        w_mul_start  = 1'b1;
                        w_state_next = ST_MUL;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_load       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_ld_res;
            r_flags     <= w_ld_flags;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (reset),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );

endmodule
`default_nettype wire
